mmr_axil_read_slave: RTL and testbench
======================================

MMR_AXIL_READ_SLAVE -- requirements
Module: mmr_axil_read_slave

Interface
REQ-001 The block SHALL have parameter NREGS, default 16: number of 32-bit read registers exposed; legal range 1..1024.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 12: AXI4-Lite address width; the build SHALL fail unless ADDR_WIDTH >= clog2(NREGS)+2.
REQ-003 The block SHALL derive localparam INDEX_WIDTH = max(1, clog2(NREGS)).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port mmr, interface mmr_read_interface#(NREGS).master: register file contents, data[i] for i = 0..NREGS-1, 32 bits each.
REQ-008 The block SHALL have port s_axil_araddr, input, ADDR_WIDTH bits: read byte address.
REQ-009 The block SHALL have port s_axil_arvalid, input, 1 bit: read address valid.
REQ-010 The block SHALL have port s_axil_arready, output, 1 bit: read address accepted.
REQ-011 The block SHALL have port s_axil_rdata, output, 32 bits: read data.
REQ-012 The block SHALL have port s_axil_rresp, output, 2 bits: 2'b00 OKAY, 2'b10 SLVERR.
REQ-013 The block SHALL have port s_axil_rvalid, output, 1 bit: read data valid.
REQ-014 The block SHALL have port s_axil_rready, input, 1 bit: master accepts read data.
REQ-015 The block SHALL have port rd_strobe, output, NREGS bits: one-cycle pulse on bit i when register i is read; used by the slave side for read-to-clear.

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE and RESP.
REQ-017 In IDLE the block SHALL drive arready = 1 and rvalid = 0.
REQ-018 In RESP the block SHALL drive arready = 0 and rvalid = 1.
REQ-019 On an AR handshake in IDLE (arvalid && arready) at cycle N, the block SHALL go to RESP at N+1.
REQ-020 The block SHALL register rdata/rresp at cycle N, so that rvalid is high from N+1 with that data: AR-to-R latency of exactly 1 cycle.
REQ-021 The block SHALL decode index = araddr[INDEX_WIDTH+1:2]; araddr[1:0] SHALL be ignored, so unaligned addresses read the containing word.
REQ-022 For an in-range access (araddr[ADDR_WIDTH-1:2] < NREGS), the block SHALL set rdata = mmr.data[index] as sampled at cycle N and rresp = 2'b00.
REQ-023 For an out-of-range access, including address bits above INDEX_WIDTH+1 being nonzero, the block SHALL set rdata = 32'h0 and rresp = 2'b10.
REQ-024 rdata and rresp SHALL stay stable while in RESP, even if mmr.data changes.
REQ-025 In RESP, the block SHALL return to IDLE at the cycle after rready = 1; if rready stays 0, the block SHALL hold RESP indefinitely.
REQ-026 The block SHALL give maximum throughput of one read per 2 cycles; the block SHALL NOT accept a new AR in the same cycle as an R handshake.
REQ-027 The block SHALL pulse rd_strobe[index] for exactly one cycle, at N+1, for in-range accesses only; all other bits and all other cycles SHALL be 0.
REQ-028 The block SHALL produce no rd_strobe for out-of-range accesses.
REQ-029 arvalid while in RESP SHALL be ignored; the address is not captured until the return to IDLE.
REQ-030 NREGS not a power of two: indices NREGS..2^INDEX_WIDTH-1 SHALL produce SLVERR.

Reset
REQ-031 While reset = 1, the block SHALL force state = IDLE, arready = 0, rvalid = 0, rdata = 0, rresp = 0 and rd_strobe = 0.
REQ-032 In the first cycle after reset deasserts, the block SHALL drive arready = 1.
REQ-033 Reset asserted in RESP SHALL drop rvalid on the next edge and discard the pending response; no strobe SHALL be re-issued.

Verification
REQ-034 The bench SHALL cover: NREGS=16, data[3]=32'hDEADBEEF, araddr=0x00C with arvalid and rready held 1 -> rvalid=1 one cycle after AR handshake, rdata=DEADBEEF, rresp=00, rd_strobe=16'h0008 for one cycle.
REQ-035 The bench SHALL cover: araddr=0x040 (index 16, NREGS=16) -> rdata=0, rresp=10, rd_strobe=0.
REQ-036 The bench SHALL cover: rready=0 for 5 cycles after rvalid while data[3] changes to 32'h12345678 -> rvalid stays 1, rdata stays DEADBEEF; R handshake on cycle 6, arready=1 the next cycle.
REQ-037 The bench SHALL cover: back-to-back arvalid with addresses 0x000, 0x004, rready=1 -> responses in order 2 cycles apart, arready low during each RESP.
REQ-038 The bench SHALL cover: reset pulsed while rvalid=1 -> rvalid=0 after the edge, arready=0 during reset, arready=1 the cycle after release, no spurious R beat.
REQ-039 The bench SHALL cover: NREGS=5, araddr=0x018 (index 6) -> SLVERR; araddr=0x013 -> data[4], OKAY.

Source files
------------

// File: rtl/mmr_axil_read_slave_if.sv
// Register-file view shared between the AXI4-Lite read slave and its owner.
// Ports: data[i], 32 bits each; master modport reads, slave modport drives.
interface mmr_read_interface #(
  parameter int NREGS = 16
);
  logic [31:0] data [NREGS];

  modport master (input data);
  modport slave (output data);
endinterface

// File: rtl/mmr_axil_read_slave.sv
// AXI4-Lite read-only slave over NREGS 32-bit registers with read strobes.
// Ports: clock/reset, mmr register view, AR/R channels, rd_strobe pulses.
module mmr_axil_read_slave #(
  parameter int NREGS = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  mmr_read_interface.master     mmr,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [NREGS-1:0]      rd_strobe
);

  localparam int INDEX_WIDTH =
    (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int EXT_WIDTH = ADDR_WIDTH + INDEX_WIDTH;
  localparam logic [EXT_WIDTH-1:0] NREGS_EXT =
    EXT_WIDTH'(NREGS);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  generate
    if (NREGS < 1 || NREGS > 1024 ||
        ADDR_WIDTH < $clog2(NREGS) + 2) begin : g_bad_cfg
      $error("mmr_axil_read_slave: illegal NREGS/ADDR_WIDTH");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [EXT_WIDTH-1:0]   word;
  logic [INDEX_WIDTH-1:0] index;
  logic                   in_range;
  logic                   ar_hs;
  logic [31:0]            sel_data;
  logic [NREGS-1:0]       strobe_d;

  // Zero-extended so the range test also sees every upper address
  // bit, and the index slice exists even for tiny address widths.
  assign word = {{INDEX_WIDTH{1'b0}}, s_axil_araddr} >> 2;
  assign index = word[INDEX_WIDTH-1:0];
  assign in_range = word < NREGS_EXT;
  assign ar_hs = s_axil_arvalid && s_axil_arready;

  always_comb begin
    sel_data = '0;
    if (in_range) begin
      sel_data = mmr.data[index];
    end
  end

  always_comb begin
    strobe_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (ar_hs && in_range &&
          index == INDEX_WIDTH'(i)) begin
        strobe_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    s_axil_arready = 1'b0;
    s_axil_rvalid = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_axil_arready = !reset;
        if (ar_hs) begin
          state_d = RESP;
        end
      end
      RESP: begin
        s_axil_rvalid = !reset;
        if (s_axil_rready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      s_axil_rdata <= '0;
      s_axil_rresp <= OKAY;
      rd_strobe <= '0;
    end else begin
      state_q <= state_d;
      rd_strobe <= strobe_d;
      // Response is captured only at the AR handshake, so it holds
      // through a stalled R channel regardless of register changes.
      if (ar_hs) begin
        s_axil_rdata <= sel_data;
        s_axil_rresp <= in_range ? OKAY : SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_mmr_axil_read_slave.sv
// Self-checking bench for mmr_axil_read_slave (NREGS=16 and NREGS=5).
// Expected responses are queued at AR issue and popped on R beats.
module tb_mmr_axil_read_slave;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] a_araddr = '0;
  logic        a_arvalid = 1'b0;
  logic        a_arready;
  logic [31:0] a_rdata;
  logic [1:0]  a_rresp;
  logic        a_rvalid;
  logic        a_rready = 1'b0;
  logic [15:0] a_strobe;

  logic [11:0] b_araddr = '0;
  logic        b_arvalid = 1'b0;
  logic        b_arready;
  logic [31:0] b_rdata;
  logic [1:0]  b_rresp;
  logic        b_rvalid;
  logic        b_rready = 1'b0;
  logic [4:0]  b_strobe;

  mmr_read_interface #(.NREGS(16)) a_mmr ();
  mmr_read_interface #(.NREGS(5)) b_mmr ();

  mmr_axil_read_slave #(.NREGS(16), .ADDR_WIDTH(12)) dut_a (
    .clock(clk), .reset(reset), .mmr(a_mmr),
    .s_axil_araddr(a_araddr), .s_axil_arvalid(a_arvalid),
    .s_axil_arready(a_arready), .s_axil_rdata(a_rdata),
    .s_axil_rresp(a_rresp), .s_axil_rvalid(a_rvalid),
    .s_axil_rready(a_rready), .rd_strobe(a_strobe)
  );

  mmr_axil_read_slave #(.NREGS(5), .ADDR_WIDTH(12)) dut_b (
    .clock(clk), .reset(reset), .mmr(b_mmr),
    .s_axil_araddr(b_araddr), .s_axil_arvalid(b_arvalid),
    .s_axil_arready(b_arready), .s_axil_rdata(b_rdata),
    .s_axil_rresp(b_rresp), .s_axil_rvalid(b_rvalid),
    .s_axil_rready(b_rready), .rd_strobe(b_strobe)
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
    logic [15:0] s;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  logic [31:0] model_a [16];
  logic [31:0] model_b [5];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic exp_t model_16(input logic [11:0] addr);
    exp_t e;
    int w;
    w = int'(addr >> 2);
    if (w < 16) begin
      e.d = model_a[w];
      e.r = 2'b00;
      e.s = 16'(1) << w;
    end else begin
      e.d = 32'h0;
      e.r = 2'b10;
      e.s = 16'h0;
    end
    return e;
  endfunction

  task automatic set_a(input int i, input logic [31:0] v);
    a_mmr.data[i] = v;
    model_a[i] = v;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (a_arready !== 1'b0 || a_rvalid !== 1'b0 ||
        a_rdata !== 32'h0 || a_rresp !== 2'b00 ||
        a_strobe !== 16'h0) begin
      $display("FAIL reset_a: ardy=%b rv=%b rd=%h rr=%b st=%h want 0",
        a_arready, a_rvalid, a_rdata, a_rresp, a_strobe);
    end else pass_cnt++;
    total_cnt++;
    if (b_arready !== 1'b0 || b_rvalid !== 1'b0 ||
        b_strobe !== 5'h0) begin
      $display("FAIL reset_b: ardy=%b rv=%b st=%h want 0",
        b_arready, b_rvalid, b_strobe);
    end else pass_cnt++;
    reset = 1'b0;
    tick();
    total_cnt++;
    if (a_arready !== 1'b1 || b_arready !== 1'b1) begin
      $display("FAIL reset_release: ardy a=%b b=%b want 1",
        a_arready, b_arready);
    end else pass_cnt++;
    e = '{d: 32'h0, r: 2'b00, s: 16'h0};
    e = e;
  endtask

  task automatic test_basic();
    exp_t e;
    a_araddr = 12'h00C;
    a_arvalid = 1'b1;
    a_rready = 1'b1;
    sb_a.push_back(model_16(12'h00C));
    tick();
    total_cnt++;
    if (a_rvalid !== 1'b1 || a_arready !== 1'b0) begin
      $display("FAIL basic_latency: rv=%b ardy=%b want 1/0",
        a_rvalid, a_arready);
    end else pass_cnt++;
    e = sb_a.pop_front();
    total_cnt++;
    if (a_rdata !== e.d || a_rresp !== e.r ||
        a_strobe !== e.s || a_rdata !== 32'hDEADBEEF) begin
      $display("FAIL basic_data: rd=%h rr=%b st=%h want %h/%b/%h",
        a_rdata, a_rresp, a_strobe, e.d, e.r, e.s);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (a_rvalid !== 1'b0 || a_arready !== 1'b1 ||
        a_strobe !== 16'h0) begin
      $display("FAIL basic_after_r: rv=%b ardy=%b st=%h want 0/1/0",
        a_rvalid, a_arready, a_strobe);
    end else pass_cnt++;
    a_arvalid = 1'b0;
    tick();
  endtask

  task automatic test_table();
    logic [11:0] addrs [5];
    exp_t e;
    addrs = '{12'h040, 12'h800, 12'h00E, 12'h03C, 12'h401};
    for (int k = 0; k < 5; k++) begin
      a_araddr = addrs[k];
      a_arvalid = 1'b1;
      a_rready = 1'b1;
      sb_a.push_back(model_16(addrs[k]));
      tick();
      a_arvalid = 1'b0;
      e = sb_a.pop_front();
      total_cnt++;
      if (a_rvalid !== 1'b1 || a_rdata !== e.d ||
          a_rresp !== e.r || a_strobe !== e.s) begin
        $display("FAIL table_%h: rv=%b rd=%h rr=%b st=%h want 1/%h/%b/%h",
          addrs[k], a_rvalid, a_rdata, a_rresp, a_strobe,
          e.d, e.r, e.s);
      end else pass_cnt++;
      tick();
      total_cnt++;
      if (a_rvalid !== 1'b0 || a_strobe !== 16'h0) begin
        $display("FAIL table_end_%h: rv=%b st=%h want 0/0",
          addrs[k], a_rvalid, a_strobe);
      end else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    exp_t e;
    a_araddr = 12'h00C;
    a_arvalid = 1'b1;
    a_rready = 1'b0;
    sb_a.push_back(model_16(12'h00C));
    tick();
    e = sb_a.pop_front();
    total_cnt++;
    if (a_rvalid !== 1'b1 || a_rdata !== e.d) begin
      $display("FAIL stall_first: rv=%b rd=%h want 1/%h",
        a_rvalid, a_rdata, e.d);
    end else pass_cnt++;
    a_araddr = 12'h004;
    set_a(3, 32'h12345678);
    for (int c = 0; c < 5; c++) begin
      tick();
      total_cnt++;
      if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF ||
          a_rresp !== 2'b00 || a_arready !== 1'b0 ||
          a_strobe !== 16'h0) begin
        $display("FAIL stall_c%0d: rv=%b rd=%h ardy=%b st=%h want 1/deadbeef/0/0",
          c, a_rvalid, a_rdata, a_arready, a_strobe);
      end else pass_cnt++;
    end
    a_arvalid = 1'b0;
    a_rready = 1'b1;
    tick();
    total_cnt++;
    if (a_rvalid !== 1'b0 || a_arready !== 1'b1 ||
        a_strobe !== 16'h0) begin
      $display("FAIL stall_release: rv=%b ardy=%b st=%h want 0/1/0",
        a_rvalid, a_arready, a_strobe);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic exp_rv;
    a_araddr = 12'h000;
    a_arvalid = 1'b1;
    a_rready = 1'b1;
    sb_a.push_back(model_16(12'h000));
    sb_a.push_back(model_16(12'h004));
    for (int c = 0; c < 4; c++) begin
      tick();
      exp_rv = (c % 2 == 0);
      total_cnt++;
      if (a_rvalid !== exp_rv || a_arready !== !exp_rv) begin
        $display("FAIL b2b_hs_c%0d: rv=%b ardy=%b want %b/%b",
          c, a_rvalid, a_arready, exp_rv, !exp_rv);
      end else pass_cnt++;
      if (a_rvalid === 1'b1 && sb_a.size() > 0) begin
        e = sb_a.pop_front();
        total_cnt++;
        if (a_rdata !== e.d || a_rresp !== e.r ||
            a_strobe !== e.s) begin
          $display("FAIL b2b_data_c%0d: rd=%h rr=%b st=%h want %h/%b/%h",
            c, a_rdata, a_rresp, a_strobe, e.d, e.r, e.s);
        end else pass_cnt++;
      end
      if (c == 0) a_araddr = 12'h004;
      if (c == 2) a_arvalid = 1'b0;
    end
    total_cnt++;
    if (sb_a.size() != 0) begin
      $display("FAIL b2b_pending: %0d left want 0", sb_a.size());
      sb_a.delete();
    end else pass_cnt++;
  endtask

  task automatic test_reset_in_resp();
    exp_t e;
    a_araddr = 12'h008;
    a_arvalid = 1'b1;
    a_rready = 1'b0;
    sb_a.push_back(model_16(12'h008));
    tick();
    a_arvalid = 1'b0;
    e = sb_a.pop_front();
    total_cnt++;
    if (a_rvalid !== 1'b1 || a_rdata !== e.d ||
        a_strobe !== e.s) begin
      $display("FAIL rst_resp_pre: rv=%b rd=%h st=%h want 1/%h/%h",
        a_rvalid, a_rdata, a_strobe, e.d, e.s);
    end else pass_cnt++;
    reset = 1'b1;
    a_rready = 1'b1;
    tick();
    total_cnt++;
    if (a_rvalid !== 1'b0 || a_arready !== 1'b0 ||
        a_rdata !== 32'h0 || a_strobe !== 16'h0) begin
      $display("FAIL rst_resp_in: rv=%b ardy=%b rd=%h st=%h want 0/0/0/0",
        a_rvalid, a_arready, a_rdata, a_strobe);
    end else pass_cnt++;
    reset = 1'b0;
    tick();
    total_cnt++;
    if (a_rvalid !== 1'b0 || a_arready !== 1'b1 ||
        a_strobe !== 16'h0) begin
      $display("FAIL rst_resp_post: rv=%b ardy=%b st=%h want 0/1/0",
        a_rvalid, a_arready, a_strobe);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (a_rvalid !== 1'b0 || a_strobe !== 16'h0) begin
      $display("FAIL rst_resp_spurious: rv=%b st=%h want 0/0",
        a_rvalid, a_strobe);
    end else pass_cnt++;
  endtask

  task automatic test_nregs5();
    logic [11:0] addrs [3];
    exp_t e;
    int w;
    addrs = '{12'h018, 12'h013, 12'h014};
    for (int k = 0; k < 3; k++) begin
      w = int'(addrs[k] >> 2);
      if (w < 5) begin
        e = '{d: model_b[w], r: 2'b00, s: 16'(1) << w};
      end else begin
        e = '{d: 32'h0, r: 2'b10, s: 16'h0};
      end
      sb_b.push_back(e);
      b_araddr = addrs[k];
      b_arvalid = 1'b1;
      b_rready = 1'b1;
      tick();
      b_arvalid = 1'b0;
      e = sb_b.pop_front();
      total_cnt++;
      if (b_rvalid !== 1'b1 || b_rdata !== e.d ||
          b_rresp !== e.r || b_strobe !== e.s[4:0]) begin
        $display("FAIL n5_%h: rv=%b rd=%h rr=%b st=%h want 1/%h/%b/%h",
          addrs[k], b_rvalid, b_rdata, b_rresp, b_strobe,
          e.d, e.r, e.s[4:0]);
      end else pass_cnt++;
      tick();
      total_cnt++;
      if (b_rvalid !== 1'b0 || b_strobe !== 5'h0) begin
        $display("FAIL n5_end_%h: rv=%b st=%h want 0/0",
          addrs[k], b_rvalid, b_strobe);
      end else pass_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) set_a(i, 32'hA000_0000 + 32'(i));
    set_a(3, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      b_mmr.data[i] = 32'hB000_0000 + 32'(i);
      model_b[i] = 32'hB000_0000 + 32'(i);
    end
    test_reset();
    test_basic();
    test_table();
    test_stall();
    test_back_to_back();
    test_reset_in_resp();
    test_nregs5();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
